nibble_add_sequencer: RTL and testbench

//  Multi-cycle controller that adds WIDTH-bit operands through one shared 4-bit ripple-carry slice.

---
 rtl/nibble_add_seq_pkg.sv | 20 ++
 rtl/nibble_rca4.sv | 22 ++
 rtl/nibble_add_sequencer.sv | 127 ++++++++++++
 tb/tb_nibble_add_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_add_seq_pkg.sv
// Shared definitions for the nibble-serial adder: state encoding,
// slice width and the idx counter width helper.
package nibble_add_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to index every nibble of a WIDTH-bit operand (at least 1).
    function automatic int idx_w(input int width);
        int n;
        n = width / NIBBLE_W;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_rca4.sv
// 4-bit ripple-carry slice built from per-bit full adders; purely combinational.
module nibble_rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    assign c[0] = ci;

    // One full adder per bit, carry rippling LSB to MSB.
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign co = c[4];

endmodule

// File: rtl/nibble_add_sequencer.sv
// Nibble-serial adder: one shared 4-bit slice, one nibble per clock, LSB first.
// Optional macro NIBBLE_ADD_SEQ_SUB_EN adds a 'sub' input for a-b.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
// start_ready is 1 only in IDLE, done_valid is 1 only in DONE, and sum/cout are
// held constant while done_valid is 1. state_o exposes the FSM state.
module nibble_add_sequencer
    import nibble_add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic [1:0]       state_o
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int IW  = idx_w(WIDTH);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [IW-1:0]     idx_q, idx_d;

    logic [3:0]        slice_s;
    logic              slice_co;

    nibble_rca4 u_slice (
        .a  (a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
        .b  (b_q[idx_q*NIBBLE_W +: NIBBLE_W]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // Register all state; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state: accept in IDLE, one nibble per cycle in RUN, hold in DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    a_d     = a;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
                    // Subtract as a + ~b + 1.
                    b_d     = sub ? ~b : b;
                    carry_d = sub | cin;
`else
                    b_d     = b;
                    carry_d = cin;
`endif
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = slice_s;
                carry_d = slice_co;
                if (idx_q == IW'(NIB - 1)) begin
                    cout_d  = slice_co;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign start_ready = (state_q == ST_IDLE);
    assign done_valid  = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed bench for nibble_add_sequencer (WIDTH=16) with hand-computed results.
module tb_nibble_add_sequencer;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    logic         sub;
`endif
    logic         done_valid;
    logic         done_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic [1:0]   state_o;

    logic [W:0]   exp_q[$];
    int           n_vec;
    int           n_err;

    nibble_add_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        .sub         (sub),
`endif
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .sum         (sum),
        .cout        (cout),
        .busy        (busy),
        .state_o     (state_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operation; exp is the hand-computed {cout,sum}. bp = DONE stall cycles.
    task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc, input logic vs, input logic [W:0] exp, input int bp);
        int guard;
        int lat;
        logic [W:0] want;
        guard = 0;
        while (!start_ready && guard < 50) begin
            tick();
            guard++;
        end
        check({tag, "_start_ready"}, 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        a   = va;
        b   = vb;
        cin = vc;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        sub = vs;
`else
        if (vs) $display("note: sub ignored in this build");
`endif
        exp_q.push_back(exp);
        tick();
        // Operands are registered: scramble inputs right after accept.
        start_valid = 1'b0;
        a   = W'($urandom_range(0, 65535));
        b   = W'($urandom_range(0, 65535));
        cin = 1'($urandom_range(0, 1));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_result"}, 32'({cout, sum}), 32'(want));
        for (int i = 0; i < bp; i++) begin
            start_valid = 1'b1;
            a = W'($urandom_range(0, 65535));
            b = W'($urandom_range(0, 65535));
            tick();
            check({tag, "_bp_valid"}, 32'(done_valid), 32'd1);
            check({tag, "_bp_ready"}, 32'(start_ready), 32'd0);
            check({tag, "_bp_hold"}, 32'({cout, sum}), 32'(want));
        end
        start_valid = 1'b0;
        done_ready  = 1'b1;
        tick();
        done_ready  = 1'b0;
        check({tag, "_drop_valid"}, 32'(done_valid), 32'd0);
        check({tag, "_back_idle"}, 32'(start_ready), 32'd1);
    endtask

    initial begin
        int pulses;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start_valid = 1'b0;
        done_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        sub = 1'b0;
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_state", 32'(state_o), 32'd0);

        // done_ready outside DONE is ignored
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check("idle_done_ready", 32'(done_valid), 32'd0);
        check("idle_state", 32'(state_o), 32'd0);

        run_op("t1",  16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555, 0);
        run_op("t2",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 0);
        run_op("t3a", 16'h0000, 16'h0000, 1'b1, 1'b0, 17'h00001, 0);
        run_op("t3b", 16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000, 0);
        run_op("t3c", 16'hABCD, 16'h1234, 1'b1, 1'b0, 17'h0BE02, 0);
        run_op("t3d", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF, 0);
        run_op("t4",  16'h0F0F, 16'h00F1, 1'b0, 1'b0, 17'h01000, 3);

        // Reset while idx=2 in RUN
        start_valid = 1'b1;
        a = 16'h1111;
        b = 16'h2222;
        cin = 1'b0;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        check("t5_in_run", 32'(state_o), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_sum", 32'(sum), 32'd0);
        check("t5_done_valid", 32'(done_valid), 32'd0);
        check("t5_start_ready", 32'(start_ready), 32'd1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done_valid) pulses++;
        end
        check("t5_no_pulse", 32'(pulses), 32'd0);
        run_op("t5_after", 16'h9999, 16'h7777, 1'b0, 1'b0, 17'h11110, 0);

`ifdef NIBBLE_ADD_SEQ_SUB_EN
        run_op("t6a", 16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE, 0);
        run_op("t6b", 16'h0007, 16'h0005, 1'b0, 1'b1, 17'h10002, 0);
        run_op("t6c", 16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
